// File: rtl/alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_ctrl
//  Purpose  : UART byte-frame command parser that drives a register-output
//             ALU and returns its 16-bit result low byte first over UART TX.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_ctrl #(
    parameter logic [7:0]  CMD_OP  = 8'hCC,
    parameter logic [7:0]  CMD_FN  = 8'hDD,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [7:0]  RX_P_DATA,
    input  logic        RX_D_VLD,
    input  logic [15:0] ALU_OUT,
    input  logic        OUT_VALID,
    input  logic        TX_BUSY,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [3:0]  ALU_FUN,
    output logic        ALU_EN,
    output logic [7:0]  TX_P_DATA,
    output logic        TX_D_VLD,
    output logic        CMD_ERR
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_GET_A    = 4'd1,
        S_GET_B    = 4'd2,
        S_GET_FN   = 4'd3,
        S_ALU_RUN  = 4'd4,
        S_WAIT_RES = 4'd5,
        S_SEND_LO  = 4'd6,
        S_GAP      = 4'd7,
        S_SEND_HI  = 4'd8
    } state_t;

    localparam logic [3:0] c_WAIT_LAST = 4'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_cnt_nxt;
    logic [15:0] r_result;
    logic [15:0] w_result_nxt;
    logic [7:0]  w_a_nxt;
    logic [7:0]  w_b_nxt;
    logic [3:0]  w_fun_nxt;
    logic        w_err_nxt;
    logic        w_en_nxt;
    logic        w_tx_vld_nxt;
    logic [7:0]  w_tx_data_nxt;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_result   <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_result   <= w_result_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_result_nxt   = r_result;
        w_a_nxt        = A;
        w_b_nxt        = B;
        w_fun_nxt      = ALU_FUN;
        w_err_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_OP) begin
                        w_state_nxt = S_GET_A;
                    end else if (RX_P_DATA == CMD_FN) begin
                        w_state_nxt = S_GET_FN;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_GET_A: begin
                if (RX_D_VLD) begin
                    w_a_nxt     = RX_P_DATA;
                    w_state_nxt = S_GET_B;
                end
            end
            S_GET_B: begin
                if (RX_D_VLD) begin
                    w_b_nxt     = RX_P_DATA;
                    w_state_nxt = S_GET_FN;
                end
            end
            S_GET_FN: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA[7:4] != 4'h0) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_fun_nxt   = RX_P_DATA[3:0];
                        w_state_nxt = S_ALU_RUN;
                    end
                end
            end
            S_ALU_RUN: begin
                w_wait_cnt_nxt = 4'd0;
                w_state_nxt    = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (OUT_VALID) begin
                    w_result_nxt = ALU_OUT;
                    w_state_nxt  = S_SEND_LO;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 4'd1;
                end
            end
            S_SEND_LO: begin
                if (!TX_BUSY) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                w_state_nxt = S_SEND_HI;
            end
            S_SEND_HI: begin
                if (!TX_BUSY) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state presents,
        // so each one lines up exactly with the state it belongs to.
        w_en_nxt     = (w_state_nxt == S_ALU_RUN);
        w_tx_vld_nxt = (w_state_nxt == S_SEND_LO) || (w_state_nxt == S_SEND_HI);
        if (w_state_nxt == S_SEND_LO) begin
            w_tx_data_nxt = w_result_nxt[7:0];
        end else if (w_state_nxt == S_SEND_HI) begin
            w_tx_data_nxt = w_result_nxt[15:8];
        end else begin
            w_tx_data_nxt = 8'h00;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            A         <= 8'h00;
            B         <= 8'h00;
            ALU_FUN   <= 4'h0;
            ALU_EN    <= 1'b0;
            TX_P_DATA <= 8'h00;
            TX_D_VLD  <= 1'b0;
            CMD_ERR   <= 1'b0;
        end else begin
            A         <= w_a_nxt;
            B         <= w_b_nxt;
            ALU_FUN   <= w_fun_nxt;
            ALU_EN    <= w_en_nxt;
            TX_P_DATA <= w_tx_data_nxt;
            TX_D_VLD  <= w_tx_vld_nxt;
            CMD_ERR   <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cmd_ctrl
//  Purpose  : Directed self-checking bench for alu_cmd_ctrl with a small
//             register-output ALU model and a UART TX byte sink.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_ctrl;

    logic        CLK;
    logic        rst_n;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        TX_BUSY;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        CMD_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    int          cyc = 0;
    int          en_cnt = 0;
    int          en_cyc = 0;
    int          err_cnt = 0;
    int          err_cyc = 0;
    logic [7:0]  tx_q[$];
    int          tx_cyc[$];
    logic        suppress_valid = 1'b0;

    alu_cmd_ctrl #(
        .CMD_OP (8'hCC),
        .CMD_FN (8'hDD),
        .TIMEOUT(4)
    ) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .RX_P_DATA(RX_P_DATA),
        .RX_D_VLD (RX_D_VLD),
        .ALU_OUT  (ALU_OUT),
        .OUT_VALID(OUT_VALID),
        .TX_BUSY  (TX_BUSY),
        .A        (A),
        .B        (B),
        .ALU_FUN  (ALU_FUN),
        .ALU_EN   (ALU_EN),
        .TX_P_DATA(TX_P_DATA),
        .TX_D_VLD (TX_D_VLD),
        .CMD_ERR  (CMD_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
        case (f)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} - {8'h00, b};
            4'd2:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // Register-output ALU: result and valid appear one cycle after ALU_EN.
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            ALU_OUT   <= 16'h0000;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= ALU_EN && !suppress_valid;
            if (ALU_EN) ALU_OUT <= alu_f(A, B, ALU_FUN);
        end
    end

    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (rst_n && TX_D_VLD && !TX_BUSY) begin
            tx_q.push_back(TX_P_DATA);
            tx_cyc.push_back(cyc);
        end
        if (ALU_EN) begin
            en_cnt = en_cnt + 1;
            en_cyc = cyc;
        end
        if (CMD_ERR) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
    end

    function automatic logic [7:0] tx_at(input int i);
        if (i < tx_q.size()) return tx_q[i];
        return 8'hxx;
    endfunction

    task automatic clear_mon();
        tx_q.delete();
        tx_cyc.delete();
        en_cnt  = 0;
        err_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget && tx_q.size() < n; i++) @(negedge CLK);
        n_tests++;
        if (tx_q.size() < n) begin
            n_fail++;
            $display("FAIL tx_wait: got %0d bytes, expected %0d", tx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        RX_P_DATA = 8'h00;
        RX_D_VLD = 1'b0;
        TX_BUSY = 1'b0;
        idle(3);
        #1;
        n_tests++;
        if ({A, B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR} !== 31'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {A, B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR});
        end
        @(negedge CLK);
        rst_n = 1'b1;
        idle(2);
        n_tests++;
        if ({ALU_EN, TX_D_VLD, CMD_ERR} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected 000", {ALU_EN, TX_D_VLD, CMD_ERR});
        end
    endtask

    task automatic test_basic();
        clear_mon();
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
        wait_tx(2, 40);
        idle(3);
        n_tests++;
        if (tx_at(0) !== 8'h08 || tx_at(1) !== 8'h00) begin
            n_fail++;
            $display("FAIL basic_tx: got %h %h expected 08 00", tx_at(0), tx_at(1));
        end
        n_tests++;
        if (en_cnt !== 1) begin
            n_fail++;
            $display("FAIL basic_en_count: got %0d expected 1", en_cnt);
        end
        n_tests++;
        if (A !== 8'h05 || B !== 8'h03 || ALU_FUN !== 4'h0) begin
            n_fail++;
            $display("FAIL basic_operands: got %h %h %h expected 05 03 0", A, B, ALU_FUN);
        end
        n_tests++;
        if (tx_cyc.size() < 2 || tx_cyc[1] - tx_cyc[0] < 2) begin
            n_fail++;
            $display("FAIL basic_gap: got %0d bytes / spacing too short, expected spacing >= 2",
                     tx_cyc.size());
        end
        n_tests++;
        if (tx_cyc.size() < 1 || tx_cyc[0] - en_cyc != 2) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 2",
                     (tx_cyc.size() > 0) ? tx_cyc[0] - en_cyc : -1);
        end
        n_tests++;
        if (err_cnt !== 0 || tx_q.size() !== 2) begin
            n_fail++;
            $display("FAIL basic_clean: got err=%0d bytes=%0d expected 0 2", err_cnt, tx_q.size());
        end
    endtask

    task automatic test_fn_reuse();
        clear_mon();
        send_byte(8'hDD); send_byte(8'h02);
        wait_tx(2, 40);
        idle(3);
        n_tests++;
        if (tx_at(0) !== 8'h0F || tx_at(1) !== 8'h00 || en_cnt !== 1) begin
            n_fail++;
            $display("FAIL fn_reuse_tx: got %h %h en=%0d expected 0f 00 en=1",
                     tx_at(0), tx_at(1), en_cnt);
        end
        n_tests++;
        if (A !== 8'h05 || B !== 8'h03 || ALU_FUN !== 4'h2) begin
            n_fail++;
            $display("FAIL fn_reuse_operands: got %h %h %h expected 05 03 2", A, B, ALU_FUN);
        end
        clear_mon();
        send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
        wait_tx(2, 40);
        idle(3);
        n_tests++;
        if (tx_at(0) !== 8'h01 || tx_at(1) !== 8'hFE) begin
            n_fail++;
            $display("FAIL mul_ff_tx: got %h %h expected 01 fe", tx_at(0), tx_at(1));
        end
    endtask

    task automatic test_errors();
        clear_mon();
        send_byte(8'h55);
        idle(5);
        n_tests++;
        if (err_cnt !== 1 || en_cnt !== 0) begin
            n_fail++;
            $display("FAIL bad_opcode: got err_cycles=%0d en=%0d expected 1 0", err_cnt, en_cnt);
        end
        clear_mon();
        send_byte(8'hDD); send_byte(8'h12);
        idle(5);
        n_tests++;
        if (err_cnt !== 1 || en_cnt !== 0) begin
            n_fail++;
            $display("FAIL bad_fn: got err_cycles=%0d en=%0d expected 1 0", err_cnt, en_cnt);
        end
        n_tests++;
        if (ALU_FUN !== 4'h2 || tx_q.size() !== 0) begin
            n_fail++;
            $display("FAIL bad_fn_hold: got fun=%h bytes=%0d expected 2 0", ALU_FUN, tx_q.size());
        end
        clear_mon();
        send_byte(8'hCC); send_byte(8'h07); send_byte(8'h02); send_byte(8'h01);
        wait_tx(2, 40);
        idle(3);
        n_tests++;
        if (tx_at(0) !== 8'h05 || tx_at(1) !== 8'h00 || err_cnt !== 0) begin
            n_fail++;
            $display("FAIL after_err_frame: got %h %h err=%0d expected 05 00 0",
                     tx_at(0), tx_at(1), err_cnt);
        end
    endtask

    task automatic test_busy();
        int held_bad;
        held_bad = 0;
        clear_mon();
        TX_BUSY = 1'b1;
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
        for (int i = 0; i < 20 && !TX_D_VLD; i++) @(negedge CLK);
        n_tests++;
        if (TX_D_VLD !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_reach_send: got %b expected 1", TX_D_VLD);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                RX_P_DATA = 8'hCC;
                RX_D_VLD  = 1'b1;
            end else begin
                RX_D_VLD  = 1'b0;
            end
            n_tests++;
            if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h08) begin
                n_fail++;
                held_bad++;
                $display("FAIL busy_hold: got vld=%b data=%h expected 1 08", TX_D_VLD, TX_P_DATA);
            end
            @(negedge CLK);
        end
        RX_D_VLD = 1'b0;
        n_tests++;
        if (tx_q.size() !== 0) begin
            n_fail++;
            $display("FAIL busy_no_advance: got %0d bytes expected 0", tx_q.size());
        end
        TX_BUSY = 1'b0;
        wait_tx(2, 40);
        idle(3);
        n_tests++;
        if (tx_at(0) !== 8'h08 || tx_at(1) !== 8'h00 || err_cnt !== 0 || en_cnt !== 1) begin
            n_fail++;
            $display("FAIL busy_release: got %h %h err=%0d en=%0d expected 08 00 0 1",
                     tx_at(0), tx_at(1), err_cnt, en_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        suppress_valid = 1'b1;
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
        for (int i = 0; i < 30 && err_cnt == 0; i++) @(negedge CLK);
        idle(10);
        suppress_valid = 1'b0;
        n_tests++;
        if (err_cnt !== 1 || en_cnt !== 1) begin
            n_fail++;
            $display("FAIL timeout_err: got err_cycles=%0d en=%0d expected 1 1", err_cnt, en_cnt);
        end
        n_tests++;
        if (err_cyc - en_cyc != 5) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d expected 5", err_cyc - en_cyc);
        end
        n_tests++;
        if (tx_q.size() !== 0) begin
            n_fail++;
            $display("FAIL timeout_no_tx: got %0d bytes expected 0", tx_q.size());
        end
        clear_mon();
        send_byte(8'hDD); send_byte(8'h00);
        wait_tx(2, 40);
        idle(3);
        n_tests++;
        if (tx_at(0) !== 8'h08 || tx_at(1) !== 8'h00) begin
            n_fail++;
            $display("FAIL timeout_recover: got %h %h expected 08 00", tx_at(0), tx_at(1));
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_byte(8'hCC); send_byte(8'h05);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({A, B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR} !== 31'h0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got %h expected 0",
                     {A, B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR});
        end
        @(negedge CLK);
        rst_n = 1'b1;
        clear_mon();
        send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
        wait_tx(1, 40);
        TX_BUSY = 1'b1;
        @(negedge CLK);
        n_tests++;
        if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'hFE || tx_at(0) !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_send_hi_setup: got vld=%b data=%h lo=%h expected 1 fe 01",
                     TX_D_VLD, TX_P_DATA, tx_at(0));
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({A, B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR} !== 31'h0) begin
            n_fail++;
            $display("FAIL reset_send_hi: got %h expected 0",
                     {A, B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR});
        end
        @(negedge CLK);
        rst_n = 1'b1;
        TX_BUSY = 1'b0;
        idle(2);
        n_tests++;
        if (tx_q.size() !== 1) begin
            n_fail++;
            $display("FAIL reset_hi_dropped: got %0d bytes expected 1", tx_q.size());
        end
        clear_mon();
        send_byte(8'hCC); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
        wait_tx(2, 40);
        idle(3);
        n_tests++;
        if (tx_at(0) !== 8'h02 || tx_at(1) !== 8'h00 || tx_q.size() !== 2) begin
            n_fail++;
            $display("FAIL reset_recover: got %h %h n=%0d expected 02 00 2",
                     tx_at(0), tx_at(1), tx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fn_reuse();
        test_errors();
        test_busy();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
